// File: rtl/div_clk_monitor.sv
// Edge detector and period monitor for a divided clock that is sampled as data in the i_clk domain.
// It measures high and low time, declares lock on a matching ratio, and flags stuck or wrong-ratio input.
//
// state        | meaning
// ST_IDLE      | monitor disabled, waiting for i_en
// ST_WAIT_EDGE | discarding the partial level, waiting for a rise
// ST_MEAS_HIGH | timing the high level
// ST_MEAS_LOW  | timing the low level; the next rise completes a period
module div_clk_monitor #(
    parameter int CNT_W    = 8,
    parameter int EXP_HALF = 4,
    parameter int TOL      = 0,
    parameter int LOCK_CNT = 2,
    parameter int SYNC_EN  = 0
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    input  logic             i_div_clk,
    input  logic             i_err_clr,
    output logic             o_rise_stb,
    output logic             o_fall_stb,
    output logic [CNT_W-1:0] o_high_cnt,
    output logic [CNT_W-1:0] o_low_cnt,
    output logic             o_meas_vld,
    output logic             o_locked,
    output logic             o_err
);

    localparam int LCK_W = $clog2(LOCK_CNT + 1);
    localparam logic [CNT_W-1:0]        CNT_MAX  = '1;
    localparam logic [LCK_W-1:0]        LOCK_TGT = LCK_W'(LOCK_CNT);
    localparam logic signed [CNT_W:0]   EXP_S    = (CNT_W+1)'(EXP_HALF);
    localparam logic signed [CNT_W:0]   TOL_S    = (CNT_W+1)'(TOL);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_EDGE = 2'd1,
        ST_MEAS_HIGH = 2'd2,
        ST_MEAS_LOW  = 2'd3
    } state_t;

    logic din;

    generate
        if (SYNC_EN != 0) begin : g_sync
            logic [1:0] sync_q;
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) sync_q <= '0;
                else          sync_q <= {sync_q[0], i_div_clk};
            end
            assign din = sync_q[1];
        end else begin : g_nosync
            assign din = i_div_clk;
        end
    endgenerate

    state_t           state_q, state_d;
    logic             s_q, s_qq;
    logic [CNT_W-1:0] run_cnt_q, run_cnt_d;
    logic [CNT_W-1:0] high_cnt_q, high_cnt_d;
    logic [CNT_W-1:0] low_cnt_q, low_cnt_d;
    logic [LCK_W-1:0] lock_cnt_q, lock_cnt_d;
    logic             meas_vld_q, meas_vld_d;
    logic             locked_q, locked_d;
    logic             err_q, err_d;
    logic             rise_stb, fall_stb;

    // Distance from the expected half period, in one extra signed bit so small counts go negative.
    function automatic logic within_tol(input logic [CNT_W-1:0] meas);
        logic signed [CNT_W:0] diff;
        diff = $signed({1'b0, meas}) - EXP_S;
        if (diff[CNT_W]) diff = -diff;
        return (diff <= TOL_S);
    endfunction

    assign rise_stb = s_q & ~s_qq & i_en;
    assign fall_stb = ~s_q & s_qq & i_en;

    always_comb begin
        run_cnt_d = run_cnt_q;
        if (rise_stb || fall_stb)    run_cnt_d = CNT_W'(1);
        else if (run_cnt_q != CNT_MAX) run_cnt_d = run_cnt_q + 1'b1;
    end

    always_comb begin
        state_d    = state_q;
        high_cnt_d = high_cnt_q;
        low_cnt_d  = low_cnt_q;
        lock_cnt_d = lock_cnt_q;
        meas_vld_d = 1'b0;
        locked_d   = locked_q;
        err_d      = err_q;
        if (i_err_clr) err_d = 1'b0;
        if (!i_en) begin
            state_d    = ST_IDLE;
            lock_cnt_d = '0;
            locked_d   = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE:      state_d = ST_WAIT_EDGE;
                ST_WAIT_EDGE: if (rise_stb) state_d = ST_MEAS_HIGH;
                ST_MEAS_HIGH: begin
                    if (fall_stb) begin
                        state_d    = ST_MEAS_LOW;
                        high_cnt_d = run_cnt_q;
                    end else if (run_cnt_q == CNT_MAX) begin
                        state_d    = ST_WAIT_EDGE;
                        lock_cnt_d = '0;
                        locked_d   = 1'b0;
                        err_d      = 1'b1;
                    end
                end
                ST_MEAS_LOW: begin
                    if (rise_stb) begin
                        state_d    = ST_MEAS_HIGH;
                        low_cnt_d  = run_cnt_q;
                        meas_vld_d = 1'b1;
                        if (within_tol(high_cnt_q) && within_tol(run_cnt_q)) begin
                            if (lock_cnt_q != LOCK_TGT) lock_cnt_d = lock_cnt_q + 1'b1;
                            locked_d = (lock_cnt_d == LOCK_TGT);
                        end else begin
                            lock_cnt_d = '0;
                            locked_d   = 1'b0;
                            err_d      = 1'b1;
                        end
                    end else if (run_cnt_q == CNT_MAX) begin
                        state_d    = ST_WAIT_EDGE;
                        lock_cnt_d = '0;
                        locked_d   = 1'b0;
                        err_d      = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= ST_IDLE;
            s_q        <= 1'b0;
            s_qq       <= 1'b0;
            run_cnt_q  <= '0;
            high_cnt_q <= '0;
            low_cnt_q  <= '0;
            lock_cnt_q <= '0;
            meas_vld_q <= 1'b0;
            locked_q   <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            s_q        <= din;
            s_qq       <= s_q;
            run_cnt_q  <= run_cnt_d;
            high_cnt_q <= high_cnt_d;
            low_cnt_q  <= low_cnt_d;
            lock_cnt_q <= lock_cnt_d;
            meas_vld_q <= meas_vld_d;
            locked_q   <= locked_d;
            err_q      <= err_d;
        end
    end

    assign o_rise_stb = rise_stb;
    assign o_fall_stb = fall_stb;
    assign o_high_cnt = high_cnt_q;
    assign o_low_cnt  = low_cnt_q;
    assign o_meas_vld = meas_vld_q;
    assign o_locked   = locked_q;
    assign o_err      = err_q;

endmodule

// File: tb/tb_div_clk_monitor.sv
// Directed bench for div_clk_monitor: per-period vector tables plus hand sequences
// for timeout, reset mid-period, synchronizer latency and disable.
module tb_div_clk_monitor;

    logic clk = 1'b0;
    logic rst_n, en, div, clr;

    logic       m_rise, m_fall, m_vld, m_lock, m_err;
    logic [7:0] m_high, m_low;
    logic       s_rise, s_fall, s_vld, s_lock, s_err;
    logic [7:0] s_high, s_low;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    div_clk_monitor dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_div_clk(div), .i_err_clr(clr),
        .o_rise_stb(m_rise), .o_fall_stb(m_fall), .o_high_cnt(m_high), .o_low_cnt(m_low),
        .o_meas_vld(m_vld), .o_locked(m_lock), .o_err(m_err)
    );

    div_clk_monitor #(.SYNC_EN(1)) dut_s (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_div_clk(div), .i_err_clr(clr),
        .o_rise_stb(s_rise), .o_fall_stb(s_fall), .o_high_cnt(s_high), .o_low_cnt(s_low),
        .o_meas_vld(s_vld), .o_locked(s_lock), .o_err(s_err)
    );

    // One record = one full input period (hi cycles high, then lo cycles low). The o_meas_vld
    // seen inside a period reports the previous period, landing 2 cycles after its rise.
    typedef struct {
        int hi;
        int lo;
        int clr_step;
        int exp_vld;
        int exp_high;
        int exp_low;
        int exp_locked;
        int exp_err;
        int err_end;
        int chk_sync;
    } rec_t;

    rec_t tbl_main[17];
    rec_t tbl_relock[3];
    rec_t tbl_sync[4];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, " rise"}, m_rise, 0);
        chk({tag, " fall"}, m_fall, 0);
        chk({tag, " high"}, m_high, 0);
        chk({tag, " low"},  m_low, 0);
        chk({tag, " vld"},  m_vld, 0);
        chk({tag, " lock"}, m_lock, 0);
        chk({tag, " err"},  m_err, 0);
        chk({tag, " s_lock"}, s_lock, 0);
        chk({tag, " s_high"}, s_high, 0);
    endtask

    task automatic run_period(input rec_t r, input string tag);
        int rp, fp, nv, srp, sfp, snv;
        int vh, vl, vk, ve, svh, svl, svk, sve;
        rp = -1; fp = -1; nv = 0; srp = -1; sfp = -1; snv = 0;
        vh = 0; vl = 0; vk = 0; ve = 0; svh = 0; svl = 0; svk = 0; sve = 0;
        for (int k = 1; k <= r.hi + r.lo; k++) begin
            div = (k <= r.hi);
            clr = (k == r.clr_step);
            step();
            if (m_rise && rp < 0) rp = k;
            if (m_fall && fp < 0) fp = k;
            if (m_vld) begin nv++; vh = m_high; vl = m_low; vk = m_lock; ve = m_err; end
            if (s_rise && srp < 0) srp = k;
            if (s_fall && sfp < 0) sfp = k;
            if (s_vld) begin snv++; svh = s_high; svl = s_low; svk = s_lock; sve = s_err; end
        end
        clr = 1'b0;
        chk({tag, " rise_pos"}, rp, 1);
        chk({tag, " fall_pos"}, fp, r.hi + 1);
        chk({tag, " vld_count"}, nv, r.exp_vld);
        if (r.exp_vld != 0) begin
            chk({tag, " high_cnt"}, vh, r.exp_high);
            chk({tag, " low_cnt"}, vl, r.exp_low);
            chk({tag, " locked_at_vld"}, vk, r.exp_locked);
            chk({tag, " err_at_vld"}, ve, r.exp_err);
        end
        chk({tag, " err_end"}, m_err, r.err_end);
        if (r.chk_sync != 0) begin
            chk({tag, " sync rise_pos"}, srp, 3);
            chk({tag, " sync fall_pos"}, sfp, r.hi + 3);
            chk({tag, " sync vld_count"}, snv, r.exp_vld);
            if (r.exp_vld != 0) begin
                chk({tag, " sync high_cnt"}, svh, r.exp_high);
                chk({tag, " sync low_cnt"}, svl, r.exp_low);
                chk({tag, " sync locked"}, svk, r.exp_locked);
                chk({tag, " sync err"}, sve, r.exp_err);
            end
        end
    endtask

    initial begin
        //               hi lo clr vld  H  L lk er end sync
        tbl_main = '{
            '{4, 4, -1, 0, 0, 0, 0, 0, 0, 0},
            '{4, 4, -1, 1, 4, 4, 0, 0, 0, 0},
            '{4, 4, -1, 1, 4, 4, 1, 0, 0, 0},
            '{4, 4, -1, 1, 4, 4, 1, 0, 0, 0},
            '{5, 5, -1, 1, 4, 4, 1, 0, 0, 0},
            '{5, 5, -1, 1, 5, 5, 0, 1, 1, 0},
            '{4, 4, -1, 1, 5, 5, 0, 1, 1, 0},
            '{4, 3, -1, 1, 4, 4, 0, 1, 1, 0},
            '{4, 4, -1, 1, 4, 3, 0, 1, 1, 0},
            '{3, 4, -1, 1, 4, 4, 0, 1, 1, 0},
            '{4, 4, -1, 1, 3, 4, 0, 1, 1, 0},
            '{4, 4,  4, 1, 4, 4, 0, 1, 0, 0},
            '{5, 5, -1, 1, 4, 4, 1, 0, 0, 0},
            '{4, 4,  2, 1, 5, 5, 0, 1, 1, 0},
            '{4, 4,  4, 1, 4, 4, 0, 1, 0, 0},
            '{4, 4, -1, 1, 4, 4, 1, 0, 0, 0},
            '{4, 4, -1, 1, 4, 4, 1, 0, 0, 0}
        };
        tbl_relock = '{
            '{4, 4, -1, 0, 0, 0, 0, 0, 1, 0},
            '{4, 4, -1, 1, 4, 4, 0, 1, 1, 0},
            '{4, 4, -1, 1, 4, 4, 1, 1, 1, 0}
        };
        tbl_sync = '{
            '{4, 4, -1, 0, 0, 0, 0, 0, 0, 1},
            '{4, 4, -1, 1, 4, 4, 0, 0, 0, 1},
            '{4, 4, -1, 1, 4, 4, 1, 0, 0, 1},
            '{4, 4, -1, 1, 4, 4, 1, 0, 0, 1}
        };

        rst_n = 1'b0; en = 1'b0; div = 1'b0; clr = 1'b0;
        repeat (3) step();
        check_all_zero("reset");
        rst_n = 1'b1;
        en = 1'b1;
        repeat (3) step();

        for (int i = 0; i < 17; i++) run_period(tbl_main[i], $sformatf("main[%0d]", i));

        // Stuck high after lock: run_cnt saturates and the measurement times out.
        div = 1'b1;
        for (int k = 1; k <= 260; k++) begin
            step();
            if (k == 1)   chk("stuck rise", m_rise, 1);
            if (k == 256) begin
                chk("stuck err_before", m_err, 0);
                chk("stuck lock_before", m_lock, 1);
            end
            if (k == 257) begin
                chk("stuck err_timeout", m_err, 1);
                chk("stuck lock_timeout", m_lock, 0);
            end
        end
        div = 1'b0;
        repeat (4) step();
        for (int i = 0; i < 3; i++) run_period(tbl_relock[i], $sformatf("relock[%0d]", i));

        // Reset asserted in the middle of a high phase, released during the low phase.
        div = 1'b1;
        repeat (2) step();
        rst_n = 1'b0;
        #1;
        check_all_zero("rst_mid");
        for (int k = 3; k <= 8; k++) begin
            div = (k <= 4);
            step();
            if (k <= 5) chk($sformatf("rst_hold lock k%0d", k), m_lock, 0);
            if (k == 5) begin
                check_all_zero("rst_hold");
                rst_n = 1'b1;
            end
        end
        for (int i = 0; i < 4; i++) run_period(tbl_sync[i], $sformatf("post_rst[%0d]", i));

        // Disable for 5 cycles while the divider keeps running.
        en = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            div = (k <= 4);
            step();
            chk($sformatf("dis rise k%0d", k), m_rise | s_rise, 0);
            chk($sformatf("dis fall k%0d", k), m_fall | s_fall, 0);
        end
        chk("dis lock", m_lock, 0);
        chk("dis sync lock", s_lock, 0);
        chk("dis high_hold", m_high, 4);
        chk("dis sync high_hold", s_high, 4);
        chk("dis sync low_hold", s_low, 4);
        chk("dis err_hold", m_err, 0);
        en = 1'b1;
        repeat (3) step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
